div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the multi-cycle MIPS CPU datapath. It sits beside the A/B operand registers and feeds the DivCtrl/MultCtrl muxes in front of HI/LO. It consumes A (dividend) and B (divisor) on a start pulse from the control unit, iterates one quotient bit per cycle, and returns the quotient (LO) and remainder (HI) with a done pulse. A divide-by-zero exception flag goes to the control unit.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/div_unit.sv | 133 +++++++++++++
 tb/tb_div_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Divider items: the FSM state encoding, the operand width and the iteration count.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;

    // Two's-complement magnitude; |0x80000000| wraps back to 0x80000000,
    // which is still the correct unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] v,
                                                     input logic              neg);
        return neg ? (DIV_WIDTH'(0) - v) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit - multi-cycle 32-bit restoring divider for the MIPS datapath.
// Produces one quotient bit per cycle, MSB first, followed by a one-cycle
// sign-fix state. Latency from an accepted start to done is 33 cycles.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset; clears all state
//   start      - request pulse, sampled only in IDLE while done is low
//   div_signed - 1 = div, 0 = divu (honoured only when DIVU_EN is defined)
//   dividend   - operand A, captured on an accepted start
//   divisor    - operand B, captured on an accepted start
//   lo / hi    - quotient / remainder, updated only in FIX
//   busy       - high during RUN and FIX
//   done       - one-cycle completion pulse
//   div_zero   - one-cycle divide-by-zero pulse, coincident with done
//
// Build option: define DIVU_EN to enable unsigned division; otherwise every
// division is signed and div_signed is ignored.
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(DIV_ITER);

    div_state_t       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic             busy_q, done_q, dz_q;

    // Signedness of the incoming request.
    logic sgn;
`ifdef DIVU_EN
    assign sgn = div_signed;
`else
    assign sgn = div_signed | 1'b1;
`endif

    logic sd, sv;
    assign sd = sgn & dividend[WIDTH-1];
    assign sv = sgn & divisor[WIDTH-1];

    // One restoring step. The shifted remainder needs 33 bits; when it is
    // >= divisor the true difference is below the divisor, so the low 32
    // bits of the subtraction are exact.
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_d, quo_d;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, dvs_q};
        rem_d   = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The cycle that shows done is still IDLE; a start there is dropped.
                    if (start && !done_q) begin
                        if (divisor == '0) begin
                            done_q <= 1'b1;
                            dz_q   <= 1'b1;
                        end else begin
                            // quo_q doubles as the dividend shift register.
                            rem_q     <= '0;
                            quo_q     <= div_abs(dividend, sd);
                            dvs_q     <= div_abs(divisor, sv);
                            neg_quo_q <= sd ^ sv;
                            neg_rem_q <= sd;
                            cnt_q     <= CW'(DIV_ITER - 1);
                            busy_q    <= 1'b1;
                            state_q   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    lo_q    <= div_abs(quo_q, neg_quo_q);
                    hi_q    <= div_abs(rem_q, neg_rem_q);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lo       = lo_q;
    assign hi       = hi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        div_signed = 1'b1;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] lo, hi;
    logic        busy, done, div_zero;

    int checks = 0;
    int fails  = 0;

    div_unit dut (
        .clock(clock), .reset(reset), .start(start), .div_signed(div_signed),
        .dividend(dividend), .divisor(divisor),
        .lo(lo), .hi(hi), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request for one cycle; returns at #1 after the accepting edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Count edges until done is seen, starting from n already elapsed.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (n < 45) begin
            @(posedge clock);
            #1 n++;
            if (done) break;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi);
        int n;
        launch(a, b);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(0, n);
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_lo"}, lo, elo);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_dz"}, 32'(div_zero), 32'd0);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        @(posedge clock);
        #1 chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        chk("rst_lo", lo, 0);
        chk("rst_hi", hi, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dz", 32'(div_zero), 0);
        @(negedge clock);
        reset = 1'b0;

        run_div("s100_7", 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("sm7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("s7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("s0_5", 32'd0, 32'd5, 32'd0, 32'd0);
        run_div("s9_4", 32'd9, 32'd4, 32'd2, 32'd1);

        // Divide by zero: immediate pulse, results untouched, never busy
        launch(32'd5, 32'd0);
        chk("dz_done", 32'(done), 1);
        chk("dz_flag", 32'(div_zero), 1);
        chk("dz_busy", 32'(busy), 0);
        chk("dz_lo", lo, 32'd2);
        chk("dz_hi", hi, 32'd1);
        @(posedge clock);
        #1;
        chk("dz_done_off", 32'(done), 0);
        chk("dz_flag_off", 32'(div_zero), 0);
        chk("dz_busy_after", 32'(busy), 0);

        // Start re-asserted at cycle 10 with different operands is ignored
        launch(32'd100, 32'd7);
        repeat (9) @(posedge clock);
        #1;
        dividend = 32'd50;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        chk("ign_busy", 32'(busy), 1);
        wait_done(10, n);
        chk("ign_lat", n, 33);
        chk("ign_lo", lo, 32'd14);
        chk("ign_hi", hi, 32'd2);

        // Reset mid-run clears outputs immediately
        launch(32'd9, 32'd4);
        repeat (14) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_lo", lo, 0);
        chk("mr_hi", hi, 0);
        @(negedge clock);
        reset = 1'b0;
        run_div("post_rst", 32'd9, 32'd4, 32'd2, 32'd1);

`ifdef DIVU_EN
        div_signed = 1'b0;
        run_div("u_ff_2", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1);
        div_signed = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
